// File: rtl/io_port_responder.sv
// io_port_responder: device side of the IN/OUT port interface.
// OUT words go out through a transmit FIFO; IN words come in through receive storage.
//
// Ports:
//   clk, RESET                 clock and synchronous active-high reset
//   out_wr, out_data, io_stall processor OUT side; io_stall means the transmit FIFO is full
//   in_rd, in_data, in_empty   processor IN side; in_data is 0 when empty
//   tx_data/valid/ready        device transmit handshake
//   rx_data/valid/ready        device receive handshake
//   tx_count                   transmit FIFO occupancy, 0..DEPTH
//   ovf                        sticky flag: an OUT was dropped
//
// Build option IO_RX_FIFO_EN:
//   defined   - receive storage is a 4-entry FIFO
//   undefined - receive storage is a single holding register
module io_port_responder #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       RESET,
  input  logic                       out_wr,
  input  logic [WIDTH-1:0]           out_data,
  output logic                       io_stall,
  input  logic                       in_rd,
  output logic [WIDTH-1:0]           in_data,
  output logic                       in_empty,
  output logic [WIDTH-1:0]           tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  input  logic [WIDTH-1:0]           rx_data,
  input  logic                       rx_valid,
  output logic                       rx_ready,
  output logic [$clog2(DEPTH):0]     tx_count,
  output logic                       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] tx_mem [DEPTH];
  logic [AW-1:0]    tx_wp;
  logic [AW-1:0]    tx_rp;
  logic [CW-1:0]    tx_cnt;
  logic             tx_full;
  logic             tx_push;
  logic             tx_pop;

  assign tx_full  = (tx_cnt == CW'(DEPTH));
  assign tx_pop   = tx_valid && tx_ready;
  // A full FIFO still takes a word when the head leaves in the same cycle.
  assign tx_push  = out_wr && (!tx_full || tx_pop);

  assign io_stall = tx_full;
  assign tx_valid = (tx_cnt != '0);
  assign tx_count = tx_cnt;
  assign tx_data  = tx_valid ? tx_mem[tx_rp] : '0;

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= out_data;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      tx_wp  <= '0;
      tx_rp  <= '0;
      tx_cnt <= '0;
      ovf    <= 1'b0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + AW'(1);
      if (tx_pop)  tx_rp <= tx_rp + AW'(1);
      unique case ({tx_push, tx_pop})
        2'b10:   tx_cnt <= tx_cnt + CW'(1);
        2'b01:   tx_cnt <= tx_cnt - CW'(1);
        default: tx_cnt <= tx_cnt;
      endcase
      if (out_wr && !tx_push) ovf <= 1'b1;
    end
  end

`ifdef IO_RX_FIFO_EN
  logic [WIDTH-1:0] rx_mem [4];
  logic [1:0]       rx_wp;
  logic [1:0]       rx_rp;
  logic [2:0]       rx_cnt;
  logic             rx_push;
  logic             rx_pop;

  assign rx_ready = (rx_cnt < 3'd4) || in_rd;
  assign rx_push  = rx_valid && rx_ready;
  assign rx_pop   = in_rd && (rx_cnt != 3'd0);
  assign in_empty = (rx_cnt == 3'd0);
  assign in_data  = in_empty ? '0 : rx_mem[rx_rp];

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp] <= rx_data;
  end

  always_ff @(posedge clk) begin
    if (RESET) begin
      rx_wp  <= '0;
      rx_rp  <= '0;
      rx_cnt <= '0;
    end else begin
      if (rx_push) rx_wp <= rx_wp + 2'd1;
      if (rx_pop)  rx_rp <= rx_rp + 2'd1;
      unique case ({rx_push, rx_pop})
        2'b10:   rx_cnt <= rx_cnt + 3'd1;
        2'b01:   rx_cnt <= rx_cnt - 3'd1;
        default: rx_cnt <= rx_cnt;
      endcase
    end
  end
`else
  logic [WIDTH-1:0] rx_hold;
  logic             rx_vld;
  logic             rx_xfer;

  // The held word may be replaced in the same cycle the processor reads it.
  assign rx_ready = !rx_vld || in_rd;
  assign rx_xfer  = rx_valid && rx_ready;
  assign in_empty = !rx_vld;
  assign in_data  = rx_vld ? rx_hold : '0;

  always_ff @(posedge clk) begin
    if (RESET) begin
      rx_vld  <= 1'b0;
      rx_hold <= '0;
    end else if (rx_xfer) begin
      rx_vld  <= 1'b1;
      rx_hold <= rx_data;
    end else if (in_rd) begin
      rx_vld  <= 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_io_port_responder.sv
// tb_io_port_responder: scoreboard bench for io_port_responder.
// Expected words are queued on drive and compared when the DUT hands them over.
module tb_io_port_responder;

  localparam int DEPTH = 4;
  localparam int WIDTH = 16;

  logic             clk = 1'b0;
  logic             RESET;
  logic             out_wr;
  logic [WIDTH-1:0] out_data;
  logic             io_stall;
  logic             in_rd;
  logic [WIDTH-1:0] in_data;
  logic             in_empty;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic [2:0]       tx_count;
  logic             ovf;

  int n_chk = 0;
  int n_bad = 0;
  logic [WIDTH-1:0] txq[$];
  logic [WIDTH-1:0] rxq[$];
  logic ovf_exp = 1'b0;

  always #5 clk = ~clk;

  io_port_responder #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk      (clk),
    .RESET    (RESET),
    .out_wr   (out_wr),
    .out_data (out_data),
    .io_stall (io_stall),
    .in_rd    (in_rd),
    .in_data  (in_data),
    .in_empty (in_empty),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .tx_count (tx_count),
    .ovf      (ovf)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Handshakes complete at the next posedge; inputs are stable here.
  always @(negedge clk) begin
    if (RESET === 1'b0) begin
      if (tx_valid && tx_ready) begin
        if (txq.size() == 0) chk("tx_unexp", 32'(tx_valid), 32'd0);
        else chk("tx_word", 32'(tx_data), 32'(txq.pop_front()));
      end
      if (in_rd && rxq.size() > 0)
        chk("in_word", 32'(in_data), 32'(rxq.pop_front()));
      if (rx_valid && rx_ready) rxq.push_back(rx_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_out(input logic [WIDTH-1:0] d);
    out_wr   = 1'b1;
    out_data = d;
    if (txq.size() < DEPTH || (tx_ready && txq.size() > 0))
      txq.push_back(d);
    else
      ovf_exp = 1'b1;
    tick();
    out_wr = 1'b0;
  endtask

  task automatic check_state(input string t);
    logic [WIDTH-1:0] te;
    logic [WIDTH-1:0] ie;
    te = (txq.size() > 0) ? txq[0] : '0;
    ie = (rxq.size() > 0) ? rxq[0] : '0;
    chk({t, ":cnt"},   32'(tx_count), 32'(txq.size()));
    chk({t, ":txv"},   32'(tx_valid), 32'(txq.size() > 0));
    chk({t, ":stall"}, 32'(io_stall), 32'(txq.size() == DEPTH));
    chk({t, ":txd"},   32'(tx_data),  32'(te));
    chk({t, ":empty"}, 32'(in_empty), 32'(rxq.size() == 0));
    chk({t, ":ind"},   32'(in_data),  32'(ie));
    chk({t, ":ovf"},   32'(ovf),      32'(ovf_exp));
  endtask

  task automatic drain(input string t);
    tx_ready = 1'b1;
    for (int i = 0; i < 16 && txq.size() > 0; i++) begin
      chk({t, ":drv"}, 32'(tx_valid), 32'd1);
      tick();
    end
    tick();
    check_state(t);
  endtask

  initial begin
    RESET = 1'b1; out_wr = 1'b0; out_data = '0; in_rd = 1'b0;
    tx_ready = 1'b0; rx_valid = 1'b0; rx_data = '0;
    tick(); tick();
    RESET = 1'b0;
    check_state("reset");
    chk("reset:rxr", 32'(rx_ready), 32'd1);

    // Device stalled, fill, then drain in order.
    drive_out(16'h1111); drive_out(16'h2222);
    drive_out(16'h3333); drive_out(16'h4444);
    check_state("fill");
    drain("drain1");

    // Full with simultaneous push and pop.
    drive_out(16'h0102); drive_out(16'h0103);
    drive_out(16'h0104); drive_out(16'h0105);
    tx_ready = 1'b1;
    drive_out(16'hAAAA);
    check_state("pushpop");
    drain("drain2");

    // Overflow while full and stalled.
    tx_ready = 1'b0;
    drive_out(16'h0201); drive_out(16'h0202);
    drive_out(16'h0203); drive_out(16'h0204);
    drive_out(16'hBEEF);
    check_state("ovf");
    drain("drain3");

    // Receive path.
    rx_valid = 1'b1; rx_data = 16'h00C3;
    tick();
    rx_valid = 1'b0;
    check_state("rx1");
    rx_valid = 1'b1; rx_data = 16'h0077;
    #1;
`ifdef IO_RX_FIFO_EN
    chk("rx2:rxr", 32'(rx_ready), 32'd1);
`else
    chk("rx2:rxr", 32'(rx_ready), 32'd0);
`endif
    tick();
    in_rd = 1'b1; rx_data = 16'h0055;
    tick();
    in_rd = 1'b0; rx_valid = 1'b0;
    check_state("rdwr");
    in_rd = 1'b1;
    for (int i = 0; i < 8 && rxq.size() > 0; i++) tick();
    tick();
    in_rd = 1'b0;
    check_state("rxempty");

    // Reset mid-operation.
    tx_ready = 1'b0;
    drive_out(16'h0301); drive_out(16'h0302); drive_out(16'h0303);
    rx_valid = 1'b1; rx_data = 16'h0099;
    tick();
    rx_valid = 1'b0;
    check_state("prerst");
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    txq.delete(); rxq.delete(); ovf_exp = 1'b0;
    check_state("midrst");
    chk("midrst:rxr", 32'(rx_ready), 32'd1);

    // Random streaming mix.
    for (int i = 0; i < 60; i++) begin
      tx_ready = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 3) != 0)
        drive_out(16'($urandom));
      else
        tick();
    end
    check_state("rand");
    drain("drain4");

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
